// File: rtl/sys_defs.sv
// Shared bus definitions for the D-cache / data-memory interface.
package sys_defs;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;

    typedef logic [31:0] PC_t;

    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t TAG_ZERO = '0;

    // Tags cycle 1..15; zero is reserved for "no tag".
    function automatic tag_t next_tag(input tag_t t);
        return (t == tag_t'(15)) ? tag_t'(1) : t + tag_t'(1);
    endfunction
endpackage

// File: rtl/mem_pending_fifo.sv
// In-order queue of outstanding loads, each carrying its tag, snapshot data and countdown.
module mem_pending_fifo
    import sys_defs::*;
#(
    parameter int QDEPTH  = 8,
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  tag_t        push_tag,
    input  logic [63:0] push_data,
    output logic        head_due,
    output logic        full_after_pop,
    output logic        next_due,
    output tag_t        due_tag,
    output logic [63:0] due_data
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

    tag_t          slot_tag_q  [QDEPTH];
    logic [63:0]   slot_data_q [QDEPTH];
    logic [3:0]    cd_q        [QDEPTH];
    logic [3:0]    cd_d        [QDEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, cand;
    logic [CW-1:0] cnt_q, cnt_d, cnt_after_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_due       = (cnt_q != '0) && (cd_q[rd_q] == 4'd0);
    assign cnt_after_pop  = cnt_q - CW'(head_due);
    assign full_after_pop = (cnt_after_pop == CW'(QDEPTH));
    assign cand           = head_due ? ptr_inc(rd_q) : rd_q;

    // Look one cycle ahead so the caller can register the completion that lands next cycle.
    always_comb begin
        next_due = 1'b0;
        due_tag  = TAG_ZERO;
        due_data = '0;
        if (cnt_after_pop != '0) begin
            next_due = (cd_q[cand] == 4'd1);
            due_tag  = slot_tag_q[cand];
            due_data = slot_data_q[cand];
        end else if (push) begin
            next_due = (CD_INIT == 4'd0);
            due_tag  = push_tag;
            due_data = push_data;
        end
    end

    always_comb begin
        rd_d  = head_due ? ptr_inc(rd_q) : rd_q;
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        cnt_d = cnt_after_pop + CW'(push);
        for (int i = 0; i < QDEPTH; i++) begin
            cd_d[i] = (cd_q[i] != 4'd0) ? cd_q[i] - 4'd1 : cd_q[i];
            if (push && (wr_q == PW'(i)))
                cd_d[i] = CD_INIT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        cd_q <= cd_d;
        if (push) begin
            slot_tag_q[wr_q]  <= push_tag;
            slot_data_q[wr_q] <= push_data;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: tags every accepted command, writes stores at once,
// and returns each load's snapshot exactly LATENCY cycles after acceptance.
module dmem_responder
    import sys_defs::*;
#(
    parameter int LATENCY      = 4,
    parameter int QDEPTH       = 8,
    parameter int MEM_WORDS    = 8192,
    parameter int REJECT_EVERY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Dcache2Dmem_command,
    input  PC_t         Dcache2Dmem_addr,
    input  logic [63:0] Dcache2Dmem_data,
    output tag_t        Dmem2Dcache_response,
    output logic [63:0] Dmem2Dcache_data,
    output tag_t        Dmem2Dcache_tag
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int RW = (REJECT_EVERY > 1) ? $clog2(REJECT_EVERY) : 1;
    localparam logic [RW-1:0] REJ_LAST = (REJECT_EVERY > 0) ? RW'(REJECT_EVERY - 1) : '0;

    logic [63:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic          unused_addr;
    logic          is_load, is_store, reject_active, load_acc, store_acc;
    logic          head_due, full_after_pop, next_due;
    tag_t          due_tag, tag_cnt_q, tag_cnt_d, out_tag_q, out_tag_d;
    logic [63:0]   due_data, out_data_q, out_data_d;
    logic [RW-1:0] rej_cnt_q, rej_cnt_d;

    assign word_idx    = Dcache2Dmem_addr[3+AW-1:3];
    assign unused_addr = ^{Dcache2Dmem_addr[2:0], Dcache2Dmem_addr[31:3+AW]};

    assign is_load       = (Dcache2Dmem_command == BUS_LOAD);
    assign is_store      = (Dcache2Dmem_command == BUS_STORE);
    assign reject_active = (REJECT_EVERY > 0) && (rej_cnt_q == REJ_LAST);
    // A completing head frees its slot for a load accepted in the same cycle.
    assign load_acc      = !reset && !reject_active && is_load && !full_after_pop;
    assign store_acc     = !reset && !reject_active && is_store;

    assign Dmem2Dcache_response = (load_acc || store_acc) ? tag_cnt_q : TAG_ZERO;
    assign Dmem2Dcache_tag      = out_tag_q;
    assign Dmem2Dcache_data     = out_data_q;

    mem_pending_fifo #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_pending (
        .clock          (clock),
        .reset          (reset),
        .push           (load_acc),
        .push_tag       (tag_cnt_q),
        .push_data      (mem[word_idx]),
        .head_due       (head_due),
        .full_after_pop (full_after_pop),
        .next_due       (next_due),
        .due_tag        (due_tag),
        .due_data       (due_data)
    );

    always_comb begin
        tag_cnt_d  = (load_acc || store_acc) ? next_tag(tag_cnt_q) : tag_cnt_q;
        rej_cnt_d  = (REJECT_EVERY == 0 || reject_active) ? '0 : rej_cnt_q + 1'b1;
        out_tag_d  = next_due ? due_tag : TAG_ZERO;
        out_data_d = next_due ? due_data : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_cnt_q  <= tag_t'(1);
            rej_cnt_q  <= '0;
            out_tag_q  <= TAG_ZERO;
            out_data_q <= '0;
        end else begin
            tag_cnt_q  <= tag_cnt_d;
            rej_cnt_q  <= rej_cnt_d;
            out_tag_q  <= out_tag_d;
            out_data_q <= out_data_d;
        end
    end

    // Backing store is never reset; its contents survive a responder reset.
    always_ff @(posedge clock) begin
        if (store_acc)
            mem[word_idx] <= Dcache2Dmem_data;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three parameterisations share one stimulus stream,
// each checked every cycle against a transaction-level model.
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd_i = 2'd0;
    logic [31:0] addr_i = '0;
    logic [63:0] data_i = '0;
    logic [3:0]  resp_w [3];
    logic [3:0]  tag_w  [3];
    logic [63:0] dat_w  [3];

    always #5 clock = ~clock;

    dmem_responder #(.LATENCY(4), .QDEPTH(8), .MEM_WORDS(8192), .REJECT_EVERY(0)) dut0 (
        .clock(clock), .reset(reset), .Dcache2Dmem_command(cmd_i), .Dcache2Dmem_addr(addr_i),
        .Dcache2Dmem_data(data_i), .Dmem2Dcache_response(resp_w[0]), .Dmem2Dcache_data(dat_w[0]),
        .Dmem2Dcache_tag(tag_w[0]));
    dmem_responder #(.LATENCY(4), .QDEPTH(2), .MEM_WORDS(8192), .REJECT_EVERY(0)) dut1 (
        .clock(clock), .reset(reset), .Dcache2Dmem_command(cmd_i), .Dcache2Dmem_addr(addr_i),
        .Dcache2Dmem_data(data_i), .Dmem2Dcache_response(resp_w[1]), .Dmem2Dcache_data(dat_w[1]),
        .Dmem2Dcache_tag(tag_w[1]));
    dmem_responder #(.LATENCY(4), .QDEPTH(8), .MEM_WORDS(8192), .REJECT_EVERY(3)) dut2 (
        .clock(clock), .reset(reset), .Dcache2Dmem_command(cmd_i), .Dcache2Dmem_addr(addr_i),
        .Dcache2Dmem_data(data_i), .Dmem2Dcache_response(resp_w[2]), .Dmem2Dcache_data(dat_w[2]),
        .Dmem2Dcache_tag(tag_w[2]));

    localparam int LAT = 4;
    int qdep [3] = '{8, 2, 8};
    int rjev [3] = '{0, 0, 3};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit armed = 0;

    logic [3:0]  resp_obs [3];
    logic [3:0]  tag_obs  [3];
    logic [63:0] dat_obs  [3];

    // Model state: memory contents, next tag, reject phase, list of outstanding loads.
    logic [63:0] mmem   [3][16];
    bit          mknown [3][16];
    int          mtag [3] = '{1, 1, 1};
    int          mrej [3] = '{0, 0, 0};
    int          qn   [3] = '{0, 0, 0};
    int          qdue [3][16];
    int          qtag [3][16];
    logic [63:0] qdat [3][16];
    bit          qkn  [3][16];

    task automatic step(input logic rst, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] wdata);
        int w;
        int exp_tag, exp_resp;
        logic [63:0] exp_dat;
        bit kn, rej, acc;
        reset = rst; cmd_i = cmd; addr_i = addr; data_i = wdata;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            resp_obs[d] = resp_w[d]; tag_obs[d] = tag_w[d]; dat_obs[d] = dat_w[d];
        end
        w = (addr >> 3) & 8191;
        for (int d = 0; d < 3; d++) begin
            exp_tag = 0; exp_dat = '0; kn = 1;
            if (qn[d] > 0 && qdue[d][0] == cyc) begin
                exp_tag = qtag[d][0]; exp_dat = qdat[d][0]; kn = qkn[d][0];
                for (int i = 0; i < 15; i++) begin
                    qdue[d][i] = qdue[d][i+1]; qtag[d][i] = qtag[d][i+1];
                    qdat[d][i] = qdat[d][i+1]; qkn[d][i] = qkn[d][i+1];
                end
                qn[d]--;
            end
            rej = (rjev[d] > 0) && (mrej[d] == rjev[d] - 1);
            acc = !rst && !rej && ((cmd == 2'd1 && qn[d] < qdep[d]) || cmd == 2'd2);
            exp_resp = acc ? mtag[d] : 0;
            if (armed) begin
                checks++;
                if (tag_obs[d] !== 4'(exp_tag)) begin
                    errors++;
                    $display("FAIL tag dut%0d cyc %0d: got %0d expected %0d", d, cyc, tag_obs[d], exp_tag);
                end
                if (kn) begin
                    checks++;
                    if (dat_obs[d] !== exp_dat) begin
                        errors++;
                        $display("FAIL data dut%0d cyc %0d: got %h expected %h", d, cyc, dat_obs[d], exp_dat);
                    end
                end
                checks++;
                if (resp_obs[d] !== 4'(exp_resp)) begin
                    errors++;
                    $display("FAIL response dut%0d cyc %0d: got %0d expected %0d", d, cyc, resp_obs[d], exp_resp);
                end
            end
            if (acc) begin
                if (cmd == 2'd2) begin
                    mmem[d][w[3:0]] = wdata; mknown[d][w[3:0]] = 1;
                end else begin
                    qdue[d][qn[d]] = cyc + LAT; qtag[d][qn[d]] = mtag[d];
                    qdat[d][qn[d]] = mmem[d][w[3:0]]; qkn[d][qn[d]] = mknown[d][w[3:0]];
                    qn[d]++;
                end
                mtag[d] = (mtag[d] == 15) ? 1 : mtag[d] + 1;
            end
            mrej[d] = (rst || rjev[d] == 0) ? 0 : (mrej[d] + 1) % rjev[d];
            if (rst) begin
                qn[d] = 0; mtag[d] = 1;
            end
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        armed = 1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (resp_obs[d] !== 4'd0 || tag_obs[d] !== 4'd0 || dat_obs[d] !== 64'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got resp %0d tag %0d data %h, required 0/0/0",
                         d, resp_obs[d], tag_obs[d], dat_obs[d]);
            end
        end
    endtask

    task automatic test_load_latency();
        step(0, 2'd2, 32'h28, 64'hA5A5);
        step(1, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            step(0, (c == 2) ? 2'd1 : 2'd0, 32'h28, 0);
            if (c == 2) begin
                checks++;
                if (resp_obs[0] !== 4'd1) begin
                    errors++; $display("FAIL load_resp: got %0d required 1", resp_obs[0]);
                end
            end
            checks++;
            if (tag_obs[0] !== ((c == 6) ? 4'd1 : 4'd0)) begin
                errors++; $display("FAIL load_tag cycle %0d: got %0d", c, tag_obs[0]);
            end
            if (c == 6) begin
                checks++;
                if (dat_obs[0] !== 64'hA5A5) begin
                    errors++; $display("FAIL load_data: got %h required a5a5", dat_obs[0]);
                end
            end
        end
    endtask

    task automatic test_store_forward();
        step(1, 0, 0, 0);
        for (int c = 0; c < 7; c++) begin
            step(0, (c == 0) ? 2'd2 : (c == 1) ? 2'd1 : 2'd0, (c == 0) ? 32'h28 : 32'h2C, 64'h1234);
            if (c < 2) begin
                checks++;
                if (resp_obs[0] !== 4'(c + 1)) begin
                    errors++; $display("FAIL fwd_resp cycle %0d: got %0d required %0d", c, resp_obs[0], c + 1);
                end
            end
            if (c == 5) begin
                checks++;
                if (tag_obs[0] !== 4'd2 || dat_obs[0] !== 64'h1234) begin
                    errors++; $display("FAIL fwd_return: got tag %0d data %h required 2/1234", tag_obs[0], dat_obs[0]);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        step(1, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step(0, (c == 0) ? 2'd1 : (c == 1) ? 2'd2 : 2'd0, 32'h28, 64'hFFFF);
            if (c == 4) begin
                checks++;
                if (tag_obs[0] !== 4'd1 || dat_obs[0] !== 64'h1234) begin
                    errors++; $display("FAIL snapshot: got tag %0d data %h required 1/1234", tag_obs[0], dat_obs[0]);
                end
            end
        end
    endtask

    task automatic test_full_queue();
        int exp_r [5] = '{1, 2, 0, 0, 3};
        step(1, 0, 0, 0);
        for (int c = 0; c < 40; c++) begin
            step(0, 2'd1, 32'h40 + 32'(c % 4) * 8, 0);
            if (c < 5) begin
                checks++;
                if (resp_obs[1] !== 4'(exp_r[c])) begin
                    errors++; $display("FAIL full_resp cycle %0d: got %0d required %0d", c, resp_obs[1], exp_r[c]);
                end
            end
        end
    endtask

    task automatic test_reject();
        step(1, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            step(0, (c < 10) ? 2'd1 : 2'd0, 32'h8, 0);
            if (c == 2 || c == 5 || c == 8) begin
                checks++;
                if (resp_obs[2] !== 4'd0) begin
                    errors++; $display("FAIL reject_resp cycle %0d: got %0d required 0", c, resp_obs[2]);
                end
            end
            if (c == 3) begin
                checks++;
                if (resp_obs[2] !== 4'd3) begin
                    errors++; $display("FAIL reject_retry: got %0d required 3", resp_obs[2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0);
        for (int c = 0; c < 3; c++) step(0, 2'd1, 32'h10, 0);
        step(1, 0, 0, 0);
        for (int c = 4; c < 12; c++) begin
            step(0, 0, 0, 0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (tag_obs[d] !== 4'd0) begin
                    errors++; $display("FAIL stale_tag dut%0d cycle %0d: got %0d required 0", d, c, tag_obs[d]);
                end
            end
        end
        step(0, 2'd2, 32'h10, 64'h77);
        checks++;
        if (resp_obs[0] !== 4'd1) begin
            errors++; $display("FAIL tag_after_reset: got %0d required 1", resp_obs[0]);
        end
    endtask

    task automatic test_random();
        logic [1:0]  cmd;
        logic [31:0] addr;
        int k;
        for (int p = 0; p < 2; p++)
            for (int w = 0; w < 16; w++)
                step(0, 2'd2, 32'(w) << 3, {$urandom(), $urandom()});
        for (int c = 0; c < 400; c++) begin
            k = $urandom_range(0, 9);
            cmd = (k < 5) ? 2'd1 : (k < 8) ? 2'd2 : (k == 8) ? 2'd0 : 2'd3;
            addr = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7));
            step($urandom_range(0, 99) < 2, cmd, addr, {$urandom(), $urandom()});
        end
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_store_forward();
        test_snapshot();
        test_full_queue();
        test_reject();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
